// File: rtl/sd_img_arbiter.sv
// rtl/sd_img_arbiter.sv - round-robin arbiter sharing one user_io SD block port among image clients
module sd_img_arbiter #(
   parameter int CHANNELS = 2,
   parameter int LBA_W    = 32,
   parameter int TIMEOUT  = 2**20
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       cl_rd,
   input  logic [CHANNELS-1:0]       cl_wr,
   input  logic [CHANNELS*LBA_W-1:0] cl_lba,
   input  logic [CHANNELS*8-1:0]     cl_din,
   output logic [CHANNELS-1:0]       cl_ack,
   output logic [CHANNELS-1:0]       cl_buff_wr,
   output logic [CHANNELS-1:0]       sd_rd,
   output logic [CHANNELS-1:0]       sd_wr,
   output logic [LBA_W-1:0]          sd_lba,
   output logic [7:0]                sd_din,
   input  logic                      sd_ack,
   input  logic                      sd_buff_wr,
   output logic                      busy,
   output logic [2:0]                grant,
   output logic                      timeout
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        grant_q, grant_d;
   logic [2:0]        last_q, last_d;
   logic [LBA_W-1:0]  lba_q, lba_d;
   logic              op_rd_q, op_rd_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              timeout_q, timeout_d;

   logic [CHANNELS-1:0] pending, gsel;
   logic                found_hi, found_lo, found, pick_rd, req_live, in_req, in_xfer;
   logic [2:0]          pick_hi, pick_lo, pick;
   logic [LBA_W-1:0]    pick_lba;

   // Round-robin pick: lowest pending index above last wins, else lowest at or below it.
   always_comb begin
      pending  = cl_rd | cl_wr;
      found_hi = 1'b0;
      found_lo = 1'b0;
      pick_hi  = '0;
      pick_lo  = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            if (i > int'(last_q)) begin
               found_hi = 1'b1;
               pick_hi  = 3'(i);
            end else begin
               found_lo = 1'b1;
               pick_lo  = 3'(i);
            end
         end
      end
      found    = found_hi | found_lo;
      pick     = found_hi ? pick_hi : pick_lo;
      pick_rd  = 1'b0;
      pick_lba = '0;
      gsel     = '0;
      sd_din   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (3'(i) == pick) begin
            pick_rd  = cl_rd[i];
            pick_lba = cl_lba[i*LBA_W +: LBA_W];
         end
         if (3'(i) == grant_q) begin
            gsel[i] = 1'b1;
            sd_din  = cl_din[i*8 +: 8];
         end
      end
      req_live = |(gsel & (op_rd_q ? cl_rd : cl_wr));
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      lba_d     = lba_q;
      op_rd_d   = op_rd_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = pick;
               lba_d   = pick_lba;
               op_rd_d = pick_rd;
               timer_d = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (timer_q != {TW{1'b1}}) timer_d = timer_q + 1'b1;
            if (sd_ack) begin
               state_d = S_XFER;
            end else if (!req_live) begin
               state_d = S_IDLE;
            end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
               last_d    = grant_q;
            end
         end
         S_XFER: begin
            if (!sd_ack) state_d = S_DONE;
         end
         S_DONE: begin
            last_d  = grant_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         last_q    <= '0;
         lba_q     <= '0;
         op_rd_q   <= 1'b0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         lba_q     <= lba_d;
         op_rd_q   <= op_rd_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   // Gating with reset lets a mid-transfer reset silence the bus in the cycle it is sampled.
   assign in_req     = (state_q == S_REQ) && !reset;
   assign in_xfer    = (state_q == S_XFER) && !reset;
   assign sd_rd      = (in_req && op_rd_q) ? gsel : '0;
   assign sd_wr      = (in_req && !op_rd_q) ? gsel : '0;
   assign cl_ack     = (in_xfer && sd_ack) ? gsel : '0;
   assign cl_buff_wr = (in_xfer && sd_buff_wr) ? gsel : '0;
   assign busy       = (state_q != S_IDLE) && !reset;
   assign timeout    = timeout_q && !reset;
   assign grant      = grant_q;
   assign sd_lba     = lba_q;
endmodule

// File: tb/tb_sd_img_arbiter.sv
// tb/tb_sd_img_arbiter.sv - randomized scoreboard bench for sd_img_arbiter
module tb_sd_img_arbiter;
   localparam int C  = 2;
   localparam int LW = 32;
   localparam int TO = 16;
   localparam int DW = C * 8;
   localparam int M_NORM = 0, M_CANCEL = 1, M_TMO = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [C-1:0]  cl_rd = '0, cl_wr = '0;
   logic [C*LW-1:0] cl_lba = '0;
   logic [DW-1:0] cl_din = '0;
   logic [C-1:0]  cl_ack, cl_buff_wr, sd_rd, sd_wr;
   logic [LW-1:0] sd_lba;
   logic [7:0]    sd_din;
   logic          sd_ack = 1'b0, sd_buff_wr = 1'b0;
   logic          busy, timeout;
   logic [2:0]    grant;

   sd_img_arbiter #(.CHANNELS(C), .LBA_W(LW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .cl_rd(cl_rd), .cl_wr(cl_wr), .cl_lba(cl_lba),
      .cl_din(cl_din), .cl_ack(cl_ack), .cl_buff_wr(cl_buff_wr), .sd_rd(sd_rd),
      .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_din(sd_din), .sd_ack(sd_ack),
      .sd_buff_wr(sd_buff_wr), .busy(busy), .grant(grant), .timeout(timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            ch;
      bit            rd;
      logic [LW-1:0] lba;
      int            mode;
      int            nstb;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;
   int   rr = 0;
   int   gch = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int winner(input int last, input logic [C-1:0] pend);
      for (int k = 1; k <= C; k++)
         if (pend[(last + k) % C]) return (last + k) % C;
      return 0;
   endfunction

   // Monitor: follows each granted transfer through request, data and done phases.
   int   ph = 0, cnt = 0, stb = 0;
   exp_t cur;
   always @(negedge clock) begin
      logic [C-1:0] rq, one;
      rq = sd_rd | sd_wr;
      if (reset) begin
         ph  = 0;
         gch = 0;
      end else begin
         if (ph == 0 && rq != '0 && exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            gch = cur.ch;
            ph  = 1;
            cnt = 0;
            stb = 0;
         end
         one = C'(1) << gch;
         chk("grant", 64'(grant), 64'(gch));
         chk("sd_din", 64'(sd_din), 64'(cl_din[gch*8 +: 8]));
         case (ph)
            0: begin
               chk("idle_req", 64'(rq), 64'd0);
               chk("idle_busy", 64'(busy), 64'd0);
               chk("idle_ack", 64'(cl_ack), 64'd0);
               chk("idle_bwr", 64'(cl_buff_wr), 64'd0);
               chk("idle_timeout", 64'(timeout), 64'd0);
            end
            1: begin
               if (rq == '0) begin
                  chk("req_len", 64'(cnt), 64'(cur.mode == M_TMO ? TO : (cur.mode == M_CANCEL ? 2 : -1)));
                  chk("timeout_pulse", 64'(timeout), 64'(cur.mode == M_TMO));
                  chk("abort_busy", 64'(busy), 64'd0);
                  ph = 0;
               end else begin
                  cnt++;
                  chk("sd_rd", 64'(sd_rd), 64'(cur.rd ? one : C'(0)));
                  chk("sd_wr", 64'(sd_wr), 64'(cur.rd ? C'(0) : one));
                  chk("sd_lba", 64'(sd_lba), 64'(cur.lba));
                  chk("req_busy", 64'(busy), 64'd1);
                  chk("req_ack", 64'(cl_ack), 64'd0);
                  chk("req_bwr", 64'(cl_buff_wr), 64'd0);
                  chk("req_timeout", 64'(timeout), 64'd0);
                  if (sd_ack) ph = 2;
               end
            end
            2: begin
               chk("xfer_req", 64'(rq), 64'd0);
               chk("xfer_busy", 64'(busy), 64'd1);
               chk("cl_ack", 64'(cl_ack), 64'(sd_ack ? one : C'(0)));
               chk("cl_buff_wr", 64'(cl_buff_wr), 64'(sd_buff_wr ? one : C'(0)));
               if (sd_buff_wr) stb++;
               if (!sd_ack) begin
                  chk("strobes", 64'(stb), 64'(cur.nstb));
                  ph = 3;
               end
            end
            default: begin
               chk("done_busy", 64'(busy), 64'd1);
               chk("done_req", 64'(rq), 64'd0);
               chk("done_ack", 64'(cl_ack), 64'd0);
               ph = 0;
            end
         endcase
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      cl_din = DW'($urandom);
   endtask

   task automatic wait_rq(input bit want, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if ((|(sd_rd | sd_wr)) == want) begin
            ok = 1'b1;
            return;
         end
      end
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: request level never became %0d within 40 cycles", want);
   endtask

   task automatic serve_batch(input logic [C-1:0] rd0, input logic [C-1:0] wr0, input int force_mode);
      int w, mode, d, len, nstb, guard;
      bit ok, op;
      logic [15:0] pat;
      cl_rd = rd0;
      cl_wr = wr0;
      for (int i = 0; i < C; i++) cl_lba[i*LW +: LW] = $urandom;
      guard = 0;
      while ((cl_rd | cl_wr) != '0 && guard < 20) begin
         guard++;
         w  = winner(rr, cl_rd | cl_wr);
         op = cl_rd[w];
         if (force_mode >= 0) mode = force_mode;
         else if ($urandom_range(0, 7) == 0) mode = M_TMO;
         else if ($urandom_range(0, 5) == 0) mode = M_CANCEL;
         else mode = M_NORM;
         force_mode = -1;
         d    = $urandom_range(0, 6);
         len  = $urandom_range(2, 6);
         pat  = 16'($urandom);
         nstb = 0;
         for (int j = 1; j < len; j++) nstb += int'(pat[j]);
         exp_q.push_back('{ch: w, rd: op, lba: cl_lba[w*LW +: LW], mode: mode, nstb: nstb});
         wait_rq(1'b1, ok);
         if (!ok) break;
         if (mode == M_NORM) begin
            step();
            repeat (d) step();
            sd_ack = 1'b1;
            for (int j = 0; j < len; j++) begin
               sd_buff_wr = pat[j];
               step();
            end
            sd_ack     = 1'b0;
            sd_buff_wr = 1'b0;
            if (op) cl_rd[w] = 1'b0; else cl_wr[w] = 1'b0;
            rr = w;
         end else if (mode == M_CANCEL) begin
            step();
            if (op) cl_rd[w] = 1'b0; else cl_wr[w] = 1'b0;
            wait_rq(1'b0, ok);
            if (!ok) break;
         end else begin
            wait_rq(1'b0, ok);
            if (!ok) break;
            rr = w;
         end
      end
      cl_rd = '0;
      cl_wr = '0;
      repeat (3) step();
      // stray ack and strobe with nothing granted must stay invisible to clients
      sd_ack     = 1'b1;
      sd_buff_wr = 1'b1;
      step();
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      step();
   endtask

   task automatic reset_in_xfer();
      bit ok;
      int w;
      cl_rd = C'($urandom_range(1, (1 << C) - 1));
      w = winner(rr, cl_rd);
      exp_q.push_back('{ch: w, rd: 1'b1, lba: cl_lba[w*LW +: LW], mode: M_NORM, nstb: 0});
      wait_rq(1'b1, ok);
      if (!ok) return;
      step();
      sd_ack = 1'b1;
      step();
      step();
      reset = 1'b1;
      @(negedge clock);
      chk("rst_req", 64'(sd_rd | sd_wr), 64'd0);
      chk("rst_ack", 64'(cl_ack), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      step();
      reset  = 1'b0;
      sd_ack = 1'b0;
      cl_rd  = '0;
      cl_wr  = '0;
      rr     = 0;
      @(negedge clock);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_lba", 64'(sd_lba), 64'd0);
      chk("rst_busy_after", 64'(busy), 64'd0);
      repeat (2) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      @(negedge clock);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_grant", 64'(grant), 64'd0);
      chk("reset_lba", 64'(sd_lba), 64'd0);
      chk("reset_timeout", 64'(timeout), 64'd0);
      chk("reset_req", 64'(sd_rd | sd_wr), 64'd0);
      step();
      serve_batch(2'b10, 2'b00, M_NORM);
      serve_batch(2'b11, 2'b00, M_NORM);
      serve_batch(2'b10, 2'b01, M_TMO);
      serve_batch(2'b01, 2'b01, M_CANCEL);
      reset_in_xfer();
      serve_batch(2'b01, 2'b00, M_NORM);
      for (int b = 0; b < 30; b++)
         serve_batch(C'($urandom), C'($urandom), -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
